// File: rtl/spi_controller_pkg.sv
// Shared types for the display SPI master: request modes, FSM states and
// the per-mode transmit/read bit counts.
package spi_types;

  typedef enum logic [1:0] {
    WRITE_8         = 2'd0,
    WRITE_16        = 2'd1,
    WRITE_8_READ_8  = 2'd2,
    WRITE_8_READ_24 = 2'd3
  } spi_mode_t;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_TX_LOW  = 3'd1,
    S_TX_HIGH = 3'd2,
    S_RX_LOW  = 3'd3,
    S_RX_HIGH = 3'd4,
    S_DONE    = 3'd5
  } spi_state_t;

  localparam logic [4:0] TX_BITS_8  = 5'd8;
  localparam logic [4:0] TX_BITS_16 = 5'd16;
  localparam logic [4:0] RX_BITS_0  = 5'd0;
  localparam logic [4:0] RX_BITS_8  = 5'd8;
  localparam logic [4:0] RX_BITS_24 = 5'd24;

  function automatic logic [4:0] tx_bits(input spi_mode_t m);
    return (m == WRITE_16) ? TX_BITS_16 : TX_BITS_8;
  endfunction

  function automatic logic [4:0] rx_bits(input spi_mode_t m);
    case (m)
      WRITE_8_READ_8:  return RX_BITS_8;
      WRITE_8_READ_24: return RX_BITS_24;
      default:         return RX_BITS_0;
    endcase
  endfunction

endpackage

// File: rtl/spi_controller.sv
// Mode-0 SPI master for the display port: one 8/16-bit write per handshake,
// optionally followed by an 8 or 24 bit read returned on o_data.
module spi_controller
  import spi_types::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [1:0]  i_mode,
  input  logic [23:0] i_data,
  output logic        o_valid,
  output logic [23:0] o_data,
  output logic        spi_csb,
  output logic        spi_clk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int PW = $clog2(CLK_DIV + 1);
  localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_DIV - 1);

  spi_state_t      state;
  spi_state_t      state_nx;
  spi_mode_t       mode_in;
  logic [PW-1:0]   phase_cnt;
  logic [4:0]      bit_cnt;
  logic [4:0]      rx_cnt;
  logic [15:0]     shreg;
  logic            phase_end;
  logic            last_bit;
  logic            handshake;
  logic            unused_data;

  assign mode_in     = spi_mode_t'(i_mode);
  assign phase_end   = (phase_cnt == '0);
  assign last_bit    = (bit_cnt == 5'd0);
  assign handshake   = i_valid && (state == S_IDLE);
  assign unused_data = ^i_data[23:16];

  always_ff @(posedge clk) begin
    if (!rstb) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (i_valid) state_nx = S_TX_LOW;
      S_TX_LOW:  if (phase_end) state_nx = S_TX_HIGH;
      S_TX_HIGH: begin
        if (phase_end) begin
          if (!last_bit)            state_nx = S_TX_LOW;
          else if (rx_cnt != 5'd0)  state_nx = S_RX_LOW;
          else                      state_nx = S_DONE;
        end
      end
      S_RX_LOW:  if (phase_end) state_nx = S_RX_HIGH;
      S_RX_HIGH: if (phase_end) state_nx = last_bit ? S_DONE : S_RX_LOW;
      S_DONE:    state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    i_ready  = 1'b0;
    o_valid  = 1'b0;
    spi_csb  = 1'b1;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    case (state)
      S_IDLE:    i_ready = 1'b1;
      S_TX_LOW:  begin spi_csb = 1'b0; spi_mosi = shreg[15]; end
      S_TX_HIGH: begin spi_csb = 1'b0; spi_mosi = shreg[15]; spi_clk = 1'b1; end
      S_RX_LOW:  spi_csb = 1'b0;
      S_RX_HIGH: begin spi_csb = 1'b0; spi_clk = 1'b1; end
      S_DONE:    o_valid = 1'b1;
      default:   ;
    endcase
  end

  // Phase/bit counters and the receive shifter; the phase counter is
  // preloaded while idle so the first LOW phase is a full CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      phase_cnt <= '0;
      bit_cnt   <= 5'd0;
      rx_cnt    <= 5'd0;
      o_data    <= 24'd0;
    end else begin
      if (state == S_IDLE) begin
        phase_cnt <= PHASE_LAST;
        if (i_valid) begin
          bit_cnt <= tx_bits(mode_in) - 5'd1;
          rx_cnt  <= rx_bits(mode_in);
          o_data  <= 24'd0;
        end
      end else if (phase_end) begin
        phase_cnt <= PHASE_LAST;
      end else begin
        phase_cnt <= phase_cnt - 1'b1;
      end
      if (phase_end && state == S_TX_HIGH)
        bit_cnt <= last_bit ? rx_cnt - 5'd1 : bit_cnt - 5'd1;
      if (phase_end && state == S_RX_HIGH) begin
        bit_cnt <= bit_cnt - 5'd1;
        o_data  <= {o_data[22:0], spi_miso};
      end
    end
  end

  // Transmit word is MSB-aligned so spi_mosi is always shreg[15].
  always_ff @(posedge clk) begin
    if (handshake)
      shreg <= (mode_in == WRITE_16) ? i_data[15:0] : {i_data[7:0], 8'h00};
    else if (state == S_TX_HIGH && phase_end)
      shreg <= {shreg[14:0], 1'b0};
  end

endmodule
